gadget_decomp: RTL and testbench
================================

# gadget_decomp

Sequential signed gadget decomposer for the TFHE key-generation datapath. It accepts one 32-bit torus value and emits `L` signed base-2^`BG_BIT` digits, most significant level first, over a valid/ready stream. It is the inverse of the multiply-accumulate recomposition performed by `Mult64`. Digits leave sign-extended to `DATA_WIDTH` so they feed a multiplier operand directly.

## Interface
- `DATA_WIDTH`, 32, torus word width.
- `BG_BIT`, 8, log2 of the gadget base Bg.
- `L`, 3, number of decomposition levels. Elaboration error unless `L*BG_BIT < DATA_WIDTH` and `BG_BIT >= 2`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_data` is offered.
- `in_ready`  out  1  block can accept; equals `rst && state==IDLE`.
- `in_data`  in  `DATA_WIDTH`  signed torus value.
- `out_valid`  out  1  `out_digit` is valid.
- `out_ready`  in  1  consumer takes the digit.
- `out_digit`  out  `DATA_WIDTH`  signed digit in [-Bg/2, Bg/2-1], sign-extended.
- `out_level`  out  `$clog2(L)` (min 1)  level index, 0 = most significant.
- `out_last`  out  1  high with the level `L-1` digit.

## Operation
- Constants:
  - `HALF = 2^(BG_BIT-1)`.
  - `OFFSET = sum over i=1..L of HALF<<(DATA_WIDTH-i*BG_BIT)`, plus `1<<(DATA_WIDTH-L*BG_BIT-1)` as the rounding bit.
  - Defaults give `OFFSET = 0x80808080`.
- FSM states: IDLE and EMIT.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`: register `tmp <= in_data + OFFSET`, truncated mod 2^`DATA_WIDTH` (wrap-around is intended and carries are discarded).
  - Set `lvl <= 0` and go to EMIT.
- EMIT:
  - `out_valid=1`.
  - `out_digit = sext(((tmp >> (DATA_WIDTH-(lvl+1)*BG_BIT)) & (Bg-1)) - HALF)`.
  - `out_level=lvl`; `out_last=(lvl==L-1)`.
- On `out_valid && out_ready`:
  - If not last: `lvl <= lvl+1`.
  - If last: go to IDLE.
- Backpressure: while `out_valid && !out_ready`, `out_digit`, `out_level` and `out_last` hold stable.
- No input is accepted in EMIT. `in_data` is sampled only on the accepting edge.
- All outputs are derived only from registers (`tmp`, `lvl`, state). There is no combinational path from `out_ready` or `in_data` to any output. `in_ready` additionally depends on `rst`.

## Timing
- Reset (`rst==0` at a rising edge):
  - State goes to IDLE; `tmp=0`, `lvl=0`.
  - `out_valid=0`, `out_digit=0`, `out_level=0`, `out_last=0`.
  - `in_ready=0` while `rst` is low.
- Reset mid-EMIT discards all remaining digits. No digit is emitted after the reset edge.
- Latency: input accepted at edge k makes the first digit visible after edge k, so `out_valid` is high in cycle k+1.
- With `out_ready` held high, levels 0..L-1 appear in consecutive cycles k+1..k+L. IDLE is re-entered at edge k+L.
- `in_ready` returns high in cycle k+L+1. Sustained throughput is one input per `L+1` cycles.
- Simultaneous `in_valid` and a final-digit handshake: the new input is not accepted that cycle; it is accepted in the following IDLE cycle.
- `out_ready` high while `out_valid` is low has no effect.

## Test plan
All values below use default parameters.
- Reset behaviour: hold `rst=0` for 2 cycles with `in_valid=1` -> `in_ready=0`, `out_valid=0`, `out_digit=0`, and no input is accepted. Release `rst`, then input `0x00000000` -> digits 0, 0, 0 with `out_last` on level 2.
- Nominal input `0x01020300`, `out_ready=1` -> digits 1, 2, 3 in cycles k+1..k+3; `in_ready` high again in cycle k+4.
- Rounding boundaries:
  - `0x0000007F` -> 0, 0, 0.
  - `0x00000080` -> 0, 0, 1.
  - `0xFFFFFF80` (-128) -> 0, 0, 0 (offset sum wraps).
- Extremes:
  - `0x7F7F7F7F` -> 127, 127, 127, each output as `0x0000007F`.
  - `0x80000000` -> -128 (`0xFFFFFF80`), 0, 0.
- Backpressure on `0x01020300`: `out_ready` low for 3 cycles at level 1 -> `out_digit` stays 2 and `out_level` stays 1; then completes 2, 3 with no digit lost or duplicated.
- Reset mid-stream: assert `rst` after level 0 of `0x01020300` -> `out_valid=0` after the reset edge. The next input `0x7F7F7F7F` yields 127, 127, 127 starting at level 0.

Source files
------------

// File: rtl/gadget_decomp.sv
// Sequential signed gadget decomposer: one torus word in, L signed base-2^BG_BIT
// digits out (most significant level first), each sign-extended to DATA_WIDTH.
module gadget_decomp #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BG_BIT     = 8,
  parameter  int L          = 3,
  localparam int LW         = (L > 1) ? $clog2(L) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_digit,
  output logic [LW-1:0]         out_level,
  output logic                  out_last,
  output logic                  state_dbg
);

  if (!((L * BG_BIT < DATA_WIDTH) && (BG_BIT >= 2))) begin : g_bad_params
    $error("gadget_decomp: need L*BG_BIT < DATA_WIDTH and BG_BIT >= 2");
  end

  localparam int HALF = 1 << (BG_BIT - 1);

  // Centres every digit field on HALF and adds the rounding bit just below the last level.
  function automatic logic [DATA_WIDTH-1:0] calc_offset();
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] half_w;
    logic [DATA_WIDTH-1:0] one_w;
    acc    = '0;
    half_w = DATA_WIDTH'(HALF);
    one_w  = DATA_WIDTH'(1);
    for (int i = 1; i <= L; i++) begin
      acc = acc + (half_w << (DATA_WIDTH - i * BG_BIT));
    end
    acc = acc + (one_w << (DATA_WIDTH - L * BG_BIT - 1));
    return acc;
  endfunction

  localparam logic [DATA_WIDTH-1:0] OFFSET = calc_offset();
  localparam logic [BG_BIT-1:0]     HALF_F = BG_BIT'(HALF);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] tmp, tmp_n;
  logic [LW-1:0]         lvl, lvl_n;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] shifted;
  logic [BG_BIT-1:0]     field;
  logic [BG_BIT-1:0]     digit;
  int                    shamt;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a held beat keeps its payload stable.

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tmp   <= '0;
      lvl   <= '0;
    end else begin
      state <= state_n;
      tmp   <= tmp_n;
      lvl   <= lvl_n;
    end
  end

  always_comb begin
    shamt   = DATA_WIDTH - (int'(lvl) + 1) * BG_BIT;
    shifted = tmp >> shamt;
    field   = shifted[BG_BIT-1:0];
    digit   = field - HALF_F;
    is_last = (lvl == LW'(L - 1));
  end

  always_comb begin
    state_n   = state;
    tmp_n     = tmp;
    lvl_n     = lvl;
    out_valid = 1'b0;
    out_digit = '0;
    out_level = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          tmp_n   = in_data + OFFSET;
          lvl_n   = '0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_digit = {{(DATA_WIDTH - BG_BIT){digit[BG_BIT-1]}}, digit};
        out_level = lvl;
        out_last  = is_last;
        if (out_ready) begin
          if (is_last) begin
            state_n = IDLE;
            lvl_n   = '0;
          end else begin
            lvl_n = lvl + LW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = rst && (state == IDLE);
  assign state_dbg = (state == EMIT);

endmodule

// File: tb/tb_gadget_decomp.sv
// Scoreboard bench for gadget_decomp: driver pushes hand-computed digits into
// exp_q, a negedge monitor compares every presented digit against the queue head.
module tb_gadget_decomp;

  localparam int W = 35; // {last, level[1:0], digit[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_digit;
  logic [1:0]  out_level;
  logic        out_last;
  logic        state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  gadget_decomp dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_level(out_level), .out_last(out_last), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] d, input int lv);
    logic [1:0] l2;
    l2 = 2'(lv);
    return {(lv == 2), l2, d};
  endfunction

  // monitor: peek while held, pop on handshake
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_digit", {out_last, out_level, out_digit}, '0);
      end else if (out_ready) begin
        check("digit", {out_last, out_level, out_digit}, exp_q.pop_front());
      end else begin
        check("held_digit", {out_last, out_level, out_digit}, exp_q[0]);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] d, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", W'(waited), W'(0));
    end else begin
      exp_q.push_back(mk(e0, 0));
      exp_q.push_back(mk(e1, 1));
      exp_q.push_back(mk(e2, 2));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", W'(exp_q.size()), W'(0));
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;

    // reset held with in_valid high
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready",  W'(in_ready),  W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_digit", W'(out_digit), W'(0));
      check("rst_out_level", W'(out_level), W'(0));
      check("rst_out_last",  W'(out_last),  W'(0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  W'(in_ready),  W'(1));
    check("post_rst_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;

    send(32'h0000_0000, 32'd0, 32'd0, 32'd0);
    drain();

    // nominal with cycle-accurate latency
    send(32'h0102_0300, 32'd1, 32'd2, 32'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("lat_out_valid", W'(out_valid), W'(1));
      check("lat_out_level", W'(out_level), W'(c));
      check("lat_in_ready",  W'(in_ready),  W'(0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("ret_in_ready",  W'(in_ready),  W'(1));
    check("ret_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;

    // rounding boundaries, back-to-back so accept waits on final handshake
    send(32'h0000_007F, 32'd0, 32'd0, 32'd0);
    send(32'h0000_0080, 32'd0, 32'd0, 32'd1);
    send(32'hFFFF_FF80, 32'd0, 32'd0, 32'd0);
    drain();

    // extremes
    send(32'h7F7F_7F7F, 32'h0000_007F, 32'h0000_007F, 32'h0000_007F);
    send(32'h8000_0000, 32'hFFFF_FF80, 32'd0, 32'd0);
    drain();

    // backpressure at level 1
    send(32'h0102_0300, 32'd1, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // reset mid-stream after level 0
    send(32'h0102_0300, 32'd1, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready",  W'(in_ready),  W'(0));
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    send(32'h7F7F_7F7F, 32'h0000_007F, 32'h0000_007F, 32'h0000_007F);
    drain();

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
